instr_sequencer: RTL and testbench

//  Upstream feeder for the cpu datapath/FSM. Holds a small program of 16-bit instructions and

---
 rtl/instr_sequencer_pkg.sv | 18 +
 rtl/instr_sequencer_mem.sv | 33 +++
 rtl/instr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//   INSTR_W : instruction width carried to the cpu
//   state_e : sequencer FSM state encoding (3 bits)
package instr_sequencer_pkg;

   localparam int unsigned INSTR_W = 16;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StStart = 3'd2,
      StAck   = 3'd3,
      StRun   = 3'd4,
      StDone  = 3'd5,
      StErr   = 3'd6
   } state_e;

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program store for the instruction sequencer: DEPTH x INSTR_W words, synchronous write,
// asynchronous read. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module instr_sequencer_mem
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues a stored program to the cpu one instruction at a time over the
// in/load/s/w handshake (load the instruction, pulse s once the cpu waits, wait for the cpu to
// accept, then wait for it to retire).
//   clk, reset          : clock, synchronous active-high reset
//   prog_we/addr/data   : program write port, honoured only in IDLE/DONE
//   count, go           : number of instructions to run and run start
//   cpu_w               : cpu waiting for s
//   cpu_in/load/s       : instruction, load strobe and start pulse to the cpu
//   pc, busy, done, err : issue slot and run status
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic [ADDR_W:0]    count,
   input  logic               go,
   input  logic               cpu_w,
   output logic [INSTR_W-1:0] cpu_in,
   output logic               cpu_load,
   output logic               cpu_s,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [7:0]         timer_q, timer_d;
   logic [INSTR_W-1:0] cpu_in_q, cpu_in_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               mem_we;
   logic [INSTR_W-1:0] mem_rdata;
   logic [INSTR_W-1:0] fetch_data;
   logic               timeout;
   logic               last;

   assign mem_we  = prog_we && ((state_q == StIdle) || (state_q == StDone));
   assign timeout = (timer_q == 8'(TIMEOUT));
   // Also stop at the top slot so pc can never wrap.
   assign last    = ({1'b0, pc_q} == (count_q - CNT_W'(1))) || (pc_q == ADDR_W'(DEPTH - 1));

   // Memory is read at the slot about to be loaded; a write in the same cycle as go wins.
   assign fetch_data = (mem_we && (prog_addr == pc_d)) ? prog_data : mem_rdata;

   instr_sequencer_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc_d),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      timer_d  = timer_q;
      cpu_in_d = cpu_in_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      cpu_s    = 1'b0;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (go) begin
               count_d = count;
               pc_d    = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               if (count == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StLoad;
                  busy_d  = 1'b1;
               end
            end
         end
         StLoad: state_d = StStart;
         StStart: begin
            if (cpu_w) begin
               cpu_s   = 1'b1;
               state_d = StAck;
            end else if (timeout) begin
               state_d = StErr;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         StAck: begin
            if (!cpu_w) begin
               state_d = StRun;
            end else if (timeout) begin
               state_d = StErr;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         StRun: begin
            if (cpu_w) begin
               if (last) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = StLoad;
               end
            end else if (timeout) begin
               state_d = StErr;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Capture the instruction on entry to LOAD so it is valid while cpu_load is high.
      if (state_d == StLoad) begin
         cpu_in_d = fetch_data;
      end

      if (state_d != state_q) begin
         timer_d = '0;
      end else if ((state_q == StStart) || (state_q == StAck) || (state_q == StRun)) begin
         timer_d = timer_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         cpu_in_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         cpu_in_q <= cpu_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign cpu_in   = cpu_in_q;
   assign cpu_load = (state_q == StLoad);
   assign pc       = pc_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer with a small behavioural cpu (MOV imm, MOV reg, ADD with shifter).
// Expected instructions are queued at go and checked at each cpu_load.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [15:0] prog_data = '0;
   logic [4:0]  count = '0;
   logic        go = 1'b0;
   logic [15:0] cpu_in;
   logic        cpu_load, cpu_s, busy, done, err;
   logic [3:0]  pc;

   // Behavioural cpu state
   logic        cw = 1'b0;
   logic        cbusy = 1'b0;
   logic        stub_low = 1'b0;
   logic [2:0]  lat = '0;
   logic [15:0] ir = '0;
   logic [15:0] rf [8];

   logic [15:0] tb_mem [16];
   logic [15:0] exp_q [$];
   int          total = 0;
   int          bad = 0;
   int          load_cnt, s_cnt, s_bad;

   always #5 clk = ~clk;

   instr_sequencer #(
      .DEPTH   (16),
      .ADDR_W  (4),
      .TIMEOUT (255)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .count     (count),
      .go        (go),
      .cpu_w     (cw),
      .cpu_in    (cpu_in),
      .cpu_load  (cpu_load),
      .cpu_s     (cpu_s),
      .pc        (pc),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   function automatic logic [15:0] shv(input logic [15:0] v, input logic [1:0] sh);
      case (sh)
         2'b01:   return {v[14:0], 1'b0};
         2'b10:   return {1'b0, v[15:1]};
         2'b11:   return {v[15], v[15:1]};
         default: return v;
      endcase
   endfunction

   always @(posedge clk) begin
      if (cpu_load) ir <= cpu_in;
      if (stub_low) begin
         cw    <= 1'b0;
         cbusy <= 1'b0;
      end else if (!cbusy) begin
         if (cw && cpu_s) begin
            cw    <= 1'b0;
            cbusy <= 1'b1;
            lat   <= 3'($urandom_range(1, 4));
         end else begin
            cw <= 1'b1;
         end
      end else if (lat != 0) begin
         lat <= lat - 3'd1;
      end else begin
         cbusy <= 1'b0;
         cw    <= 1'b1;
         if (ir[15:11] == 5'b11010) rf[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
         else if (ir[15:11] == 5'b11000) rf[ir[7:5]] <= shv(rf[ir[2:0]], ir[4:3]);
         else if (ir[15:11] == 5'b10100) rf[ir[7:5]] <= rf[ir[10:8]] + shv(rf[ir[2:0]], ir[4:3]);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (cpu_load) begin
         load_cnt++;
         if (exp_q.size() == 0) check_eq("ld_extra", 32'(cpu_load), 0);
         else check_eq("ld_instr", 32'(cpu_in), 32'(exp_q.pop_front()));
      end
      if (cpu_s) begin
         s_cnt++;
         if (!cw) s_bad++;
      end
   endtask

   task automatic prog(input int a, input logic [15:0] d);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(a);
      prog_data = d;
      tb_mem[a] = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic start(input int n);
      load_cnt = 0;
      s_cnt    = 0;
      s_bad    = 0;
      for (int i = 0; i < n; i++) exp_q.push_back(tb_mem[i]);
      go    = 1'b1;
      count = 5'(n);
      step();
      go      = 1'b0;
      prog_we = 1'b0;
   endtask

   task automatic run_until(input int budget, output int n);
      n = 0;
      while (!(done || err) && n < budget) begin
         step();
         n++;
      end
      if (!(done || err)) check_eq("budget", 32'(n), 32'(budget) + 1);
      check_eq("qleft", 32'(exp_q.size()), 0);
      check_eq("s_while_w0", 32'(s_bad), 0);
   endtask

   initial begin
      int n;
      bit seen;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_pc", 32'(pc), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_in", 32'(cpu_in), 0);
      check_eq("rst_load", 32'(cpu_load), 0);
      check_eq("rst_s", 32'(cpu_s), 0);

      // 1: single instruction
      prog(0, 16'hD069);
      prog(1, 16'hC048);
      start(1);
      run_until(500, n);
      check_eq("t1_loads", 32'(load_cnt), 1);
      check_eq("t1_s", 32'(s_cnt), 1);
      check_eq("t1_r0", 32'(rf[0]), 32'h0069);
      check_eq("t1_done", 32'(done), 1);
      check_eq("t1_busy", 32'(busy), 0);
      check_eq("t1_pc", 32'(pc), 0);

      // 2: MOV R2,#8; MOV R1,R2; ADD R1,R2,R1,LSR#1 -> 8 + 4
      prog(0, 16'hD208);
      prog(1, 16'hC022);
      prog(2, 16'hA231);
      start(3);
      check_eq("t2_busy", 32'(busy), 1);
      run_until(500, n);
      check_eq("t2_r1", 32'(rf[1]), 32'h000C);
      check_eq("t2_s", 32'(s_cnt), 3);
      check_eq("t2_done", 32'(done), 1);
      check_eq("t2_pc", 32'(pc), 2);

      // 3: count 0
      start(0);
      check_eq("t3_done", 32'(done), 1);
      check_eq("t3_busy", 32'(busy), 0);
      repeat (3) step();
      check_eq("t3_loads", 32'(load_cnt), 0);
      check_eq("t3_s", 32'(s_cnt), 0);

      // 6: program write while busy is ignored
      start(3);
      repeat (2) step();
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 16'hD4FF;
      step();
      prog_we = 1'b0;
      run_until(500, n);
      start(1);
      run_until(500, n);
      check_eq("t6_r2", 32'(rf[2]), 32'h0008);

      // 5: reset during RUN of slot 1
      start(3);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         if (cpu_s && pc == 4'd1) seen = 1'b1;
      end
      check_eq("t5_seen", 32'(seen), 1);
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
      check_eq("t5_pc", 32'(pc), 0);
      check_eq("t5_busy", 32'(busy), 0);
      check_eq("t5_done", 32'(done), 0);
      check_eq("t5_err", 32'(err), 0);
      check_eq("t5_in", 32'(cpu_in), 0);
      check_eq("t5_load", 32'(cpu_load), 0);
      check_eq("t5_s", 32'(cpu_s), 0);
      repeat (8) step();
      start(3);
      run_until(500, n);
      check_eq("t5_r1", 32'(rf[1]), 32'h000C);
      check_eq("t5_rdone", 32'(done), 1);

      // 4: cpu never waits -> timeout in START
      stub_low = 1'b1;
      repeat (2) step();
      start(1);
      run_until(1000, n);
      check_eq("t4_cycles", 32'(n + 1), 258);
      check_eq("t4_err", 32'(err), 1);
      check_eq("t4_busy", 32'(busy), 0);
      check_eq("t4_s", 32'(s_cnt), 0);
      stub_low = 1'b0;
      repeat (3) step();
      start(1);
      check_eq("t4_errclr", 32'(err), 0);
      check_eq("t4_busy2", 32'(busy), 1);
      run_until(500, n);
      check_eq("t4_done", 32'(done), 1);

      // Write together with go: the run sees the new word
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 16'hD07B;
      tb_mem[0] = 16'hD07B;
      start(1);
      run_until(500, n);
      check_eq("wg_r0", 32'(rf[0]), 32'h007B);

      // Full program: pc ends at DEPTH-1 without wrapping
      for (int k = 0; k < 16; k++) prog(k, {5'b11010, 3'(k), 8'(k)});
      start(16);
      run_until(3000, n);
      check_eq("full_loads", 32'(load_cnt), 16);
      check_eq("full_pc", 32'(pc), 15);
      check_eq("full_r7", 32'(rf[7]), 32'h000F);
      check_eq("full_r0", 32'(rf[0]), 32'h0008);
      check_eq("full_done", 32'(done), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
